// File: rtl/tdc_readout_uart.sv
// TDC result readout: buffers result words in a small FIFO and streams each
// one over an 8N1 UART as a 4-byte frame {0xA5, word[23:16], word[15:8], word[7:0]}.
module tdc_readout_uart #(
  parameter int DIG_OUT      = 24,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          iClk,
  input  logic                          iRst,
  input  logic                          iValid,
  input  logic [DIG_OUT-1:0]            iTDC,
  output logic                          oTx,
  output logic                          oBusy,
  output logic                          oOverflow,
  output logic [$clog2(FIFO_DEPTH):0]   oCount
);

  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam int              PW        = (DIG_OUT < 24) ? DIG_OUT : 24;
  localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]     FULL_LVL  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [7:0]      SYNC      = 8'hA5;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_nxt;

  logic [DIG_OUT-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;
  logic               overflow;
  logic               full;
  logic               empty;
  logic               pop;
  logic               push;
  logic [23:0]        head24;

  logic [15:0]        baud_cnt;
  logic [2:0]         bit_cnt;
  logic [1:0]         byte_idx;
  logic [31:0]        shreg;
  logic [7:0]         cur_byte;
  logic               baud_done;

  assign full      = (count == FULL_LVL);
  assign empty     = (count == '0);
  assign pop       = (state == IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push      = iValid && (!full || pop);
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign cur_byte  = shreg[31:24];

  always_comb begin
    head24         = '0;
    head24[PW-1:0] = mem[rd_ptr][PW-1:0];
  end

  // ---------------- FIFO ----------------
  always_ff @(posedge iClk) begin
    if (!iRst && push) begin
      mem[wr_ptr] <= iTDC;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (iValid && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------- FSM: state register and datapath ----------------
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          byte_idx <= '0;
          if (pop) begin
            shreg <= {SYNC, head24};
          end
        end
        START: begin
          baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_cnt  <= bit_cnt + 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            byte_idx <= byte_idx + 1'b1;
            // Next byte moves into the top lane; the frame was fully latched at pop.
            shreg    <= {shreg[23:0], 8'h00};
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          baud_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = START;
      START:   if (baud_done) state_nxt = DATA;
      DATA:    if (baud_done && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP:    if (baud_done) state_nxt = (byte_idx == 2'd3) ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    oTx = 1'b1;
    case (state)
      IDLE:    oTx = 1'b1;
      START:   oTx = 1'b0;
      DATA:    oTx = cur_byte[bit_cnt];
      STOP:    oTx = 1'b1;
      default: oTx = 1'b1;
    endcase
  end

  assign oBusy     = !empty || (state != IDLE);
  assign oOverflow = overflow;
  assign oCount    = count;

endmodule

// File: doc/tdc_readout_uart.md
TDC_READOUT_UART -- requirements
Module: tdc_readout_uart

Interface
REQ-001 Parameter DIG_OUT, default 24: width of one TDC result word (7 fine + 7 decode + 10 coarse).
REQ-002 Parameter CLKS_PER_BIT, default 868: iClk cycles per UART bit (115200 baud at 100 MHz), range 2..65535.
REQ-003 Parameter FIFO_DEPTH, default 8: result words buffered; power of two, 2..64.
REQ-004 iClk  input  1  single clock; all logic on rising edge.
REQ-005 iRst  input  1  reset, synchronous, active-high.
REQ-006 iValid  input  1  one-cycle strobe; iTDC holds a new result this cycle.
REQ-007 iTDC  input  DIG_OUT  TDC result word, sampled only when iValid=1.
REQ-008 oTx  output  1  UART serial line, 8N1, idle high.
REQ-009 oBusy  output  1  high while FIFO is non-empty or a frame is in flight.
REQ-010 oOverflow  output  1  sticky; a word was dropped because the FIFO was full.
REQ-011 oCount  output  log2(FIFO_DEPTH)+1  current FIFO fill level.

Function
REQ-012 Each word SHALL be sent as a 4-byte frame: sync 0xA5, then iTDC[23:16], iTDC[15:8], iTDC[7:0] (MSB byte first, bits above DIG_OUT zero-padded).
REQ-013 Each byte SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly CLKS_PER_BIT cycles.
REQ-014 Bytes within a frame SHALL be back-to-back: next start bit immediately follows the previous stop bit; frame length = 40*CLKS_PER_BIT cycles.
REQ-015 FSM states: IDLE, START, DATA, STOP; bit counter 0..7, byte index 0..3, baud counter 0..CLKS_PER_BIT-1.
REQ-016 IDLE: oTx=1; if FIFO non-empty, pop head into a 32-bit shift register {0xA5, word}, byte index=0, go to START next cycle.
REQ-017 START -> DATA after CLKS_PER_BIT cycles; DATA -> STOP after 8 bits; STOP -> START (byte index+1) if byte index<3, else IDLE.
REQ-018 Latency: iValid high in cycle N with FIFO empty and FSM in IDLE -> word written at end of N, popped in N+1, oTx low from cycle N+2.
REQ-019 Between consecutive frames oTx SHALL be high for exactly one IDLE cycle.
REQ-020 Write when iValid=1 and (FIFO not full or a pop occurs the same cycle); simultaneous write and pop SHALL leave oCount unchanged.
REQ-021 iValid=1 while full with no pop: word dropped, FIFO contents unchanged, oOverflow=1 from the next cycle until reset.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; order strictly first-in first-out.
REQ-023 oBusy = (oCount!=0) or (state!=IDLE), registered-consistent with oCount and state in the same cycle.
REQ-024 iValid during transmission SHALL never alter the frame in flight.

Reset
REQ-025 iRst=1 at a rising edge SHALL set, from the next cycle: state=IDLE, oTx=1, FIFO empty, oCount=0, oBusy=0, oOverflow=0, all counters 0.
REQ-026 Reset mid-frame SHALL abort the frame immediately (oTx=1 next cycle) and discard all buffered words; no partial byte resumes afterwards.
REQ-027 iValid during the reset cycle SHALL be ignored.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=8)
REQ-028 Single word: iValid with iTDC=24'h123456 at cycle 10 -> oTx low at cycle 12; decoded bytes A5,12,34,56; A5 bit pattern 1,0,1,0,0,1,0,1; oBusy low at cycle 172.
REQ-029 Back-to-back: words 24'h000001 and 24'hFFFFFF one cycle apart -> two frames, second start bit exactly 161 cycles after the first, oCount peaks at 1.
REQ-030 Overflow: iValid on 10 consecutive cycles from idle -> words 0..8 accepted, word 9 dropped, oCount=8, oOverflow=1; 9 frames emitted in order.
REQ-031 Full plus pop: FIFO full, iValid coincident with IDLE pop -> word accepted, oCount stays 8, oOverflow stays 0.
REQ-032 Reset mid-frame: iRst during DATA of byte 2 with 3 words queued -> oTx=1, oCount=0, oBusy=0 next cycle; no further start bits without new iValid.
REQ-033 Wrap-around: 20 words fed at one per frame period -> all 20 frames correct, pointers wrap twice, oOverflow=0.
